sr_sipo_4bit: RTL and testbench
===============================

// Module: sr_sipo_4bit
// PURPOSE
//   Serial-in, parallel-out shift register, 4 bits wide by default.
//   - Captures one serial bit per rising clock edge.
//   - Presents the last WIDTH captured bits in parallel on pout.
//   - Used as a deserialiser front-end: a serial data line in, a parallel word to downstream logic.
// PARAMETERS
//   WIDTH  4  shift register length, which is also the pout width; legal range >= 2
// PORTS  (port declaration order is fixed: sin, clk, rst, pout; instances connect positionally)
//   clk   in   1      clock; all state updates on the rising edge
//   rst   in   1      synchronous reset, active-low; 0 clears the register at the next rising clk
//   sin   in   1      serial data input, sampled on rising clk
//   pout  out  WIDTH  parallel output = register contents, driven directly from flops
// BEHAVIOUR
//   - Single clock domain, one clock: clk.
//   - Reset is synchronous and active-low, on port rst.
//   - Reset: at a rising clk with rst==0, pout <= 0 (all bits).
//     - sin is ignored during reset.
//     - Reset has priority over shifting.
//   - Shift: at a rising clk with rst==1, pout <= {sin, pout[WIDTH-1:1]}.
//     - New bit enters at the MSB.
//     - Contents move toward the LSB.
//     - pout[0] is discarded.
//   - Latency:
//     - sin appears on pout[WIDTH-1] one clock after sampling.
//     - It reaches pout[0] after WIDTH clocks.
//     - A full word is valid WIDTH clocks after the first bit; the first-shifted bit sits in pout[0].
//   - No enable and no handshake: the register shifts on every non-reset clock edge.
//   - Power-up: pout is undefined until the first clocked reset.
//     - Sim shows X; the register is not initialised in RTL.
//   - Reset mid-stream: the partial word is lost and pout reads 0 the cycle after.
//     - Shifting resumes on the first edge with rst==1.
//   - rst is sampled only at rising clk; changes between edges have no effect.
//   - Output is purely registered; no combinational path from sin or rst to pout.
// STRUCTURE
//   - No shared package needed; WIDTH is the only constant.
//   - Optional sub-module sipo_dff_bit:
//     - Contents: one D flop with synchronous active-low clear.
//     - Instantiation: WIDTH copies via a generate loop.
//     - Chain: bit i's D = bit i+1's Q; the MSB's D = sin.
//   - A single always block is equally acceptable; behaviour must be identical.
// TESTING
//   - Reset: rst=0 for 1 clk with sin=1 -> pout==4'b0000; it stays 0 while rst==0.
//   - Shift sequence: rst=1; drive sin=1,0,1,1 on 4 clks -> pout==1000, 0100, 1010, 1101 after each edge.
//   - Flush: after 1101, drive sin=0 for 4 clks -> 0110, 0011, 0001, 0000.
//   - Alternating: drive sin 0,1,0,1,0,1,0,1 (bench period 50, sin updates every 60).
//     -> after each edge, pout equals the last 4 sampled bits with the newest in the MSB.
//   - Reset mid-stream: load 1111, then rst=0 for one edge -> 0000.
//     -> next edge with rst=1, sin=1 -> 1000.
//   - Async-glitch check: pulse rst low between clk edges only -> pout unchanged (reset is synchronous).

Source files
------------

// File: rtl/sr_sipo_4bit_pkg.sv
// Shared constants and the per-bit next-state rule for the SIPO shift register.
package sr_sipo_4bit_pkg;

  localparam int SIPO_DEFAULT_WIDTH = 4;

  // Synchronous active-low clear takes priority over loading new data.
  function automatic logic sipo_next_q(input logic rst_n, input logic d);
    return rst_n ? d : 1'b0;
  endfunction

endpackage

// File: rtl/sr_sipo_4bit_if.sv
// Serial-in / parallel-out signal bundle; the master drives the serial line, the slave returns the word.
interface sr_sipo_4bit_if #(
  parameter int WIDTH = 4
);

  logic             sin;
  logic [WIDTH-1:0] pout;

  modport master (output sin, input pout);
  modport slave  (input sin, output pout);

endinterface

// File: rtl/sr_sipo_4bit_dff_bit.sv
// One shift-register cell: a D flop with synchronous active-low clear.
module sr_sipo_4bit_dff_bit
  import sr_sipo_4bit_pkg::*;
(
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    r_q <= sipo_next_q(i_rst_n, i_d);
  end

  assign o_q = r_q;

endmodule

// File: rtl/sr_sipo_4bit.sv
// Serial-in, parallel-out shift register: new bits enter at the MSB and move toward the LSB each clock.
module sr_sipo_4bit
  import sr_sipo_4bit_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             sin,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] pout
);

  logic [WIDTH-1:0] w_d;

  // Each cell loads from its upper neighbour; the MSB cell loads the serial input.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == WIDTH - 1) begin : g_msb
      assign w_d[i] = sin;
    end else begin : g_mid
      assign w_d[i] = pout[i+1];
    end

    sr_sipo_4bit_dff_bit u_bit (
      .clk     (clk),
      .i_rst_n (rst),
      .i_d     (w_d[i]),
      .o_q     (pout[i])
    );
  end

endmodule

// File: tb/tb_sr_sipo_4bit.sv
// Directed bench for sr_sipo_4bit: reset, shifting, flush, free-running input, mid-stream reset, rst glitch.
module tb_sr_sipo_4bit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [3:0] alt_exp [10];

  sr_sipo_4bit_if #(.WIDTH(4)) u_if ();

  sr_sipo_4bit #(.WIDTH(4)) dut (
    .sin  (u_if.sin),
    .clk  (clk),
    .rst  (rst),
    .pout (u_if.pout)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s);
    u_if.sin = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    alt_exp = '{4'b0000, 4'b1000, 4'b1100, 4'b0110, 4'b1011,
                4'b0101, 4'b1010, 4'b0101, 4'b0010, 4'b1001};
    rst      = 1'b0;
    u_if.sin = 1'b1;

    // Reset with sin held high
    @(posedge clk);
    @(negedge clk);
    check("reset_clear", u_if.pout, 4'b0000);
    step(1'b1);
    check("reset_hold", u_if.pout, 4'b0000);

    // Shift 1,0,1,1
    rst = 1'b1;
    step(1'b1); check("shift0", u_if.pout, 4'b1000);
    step(1'b0); check("shift1", u_if.pout, 4'b0100);
    step(1'b1); check("shift2", u_if.pout, 4'b1010);
    step(1'b1); check("shift3", u_if.pout, 4'b1101);

    // Flush with zeros
    step(1'b0); check("flush0", u_if.pout, 4'b0110);
    step(1'b0); check("flush1", u_if.pout, 4'b0011);
    step(1'b0); check("flush2", u_if.pout, 4'b0001);
    step(1'b0); check("flush3", u_if.pout, 4'b0000);

    // sin alternates every 60 time units against a 50-unit clock
    fork
      begin
        #10 u_if.sin = 1'b0;
        #60 u_if.sin = 1'b1;
        #60 u_if.sin = 1'b0;
        #60 u_if.sin = 1'b1;
        #60 u_if.sin = 1'b0;
        #60 u_if.sin = 1'b1;
        #60 u_if.sin = 1'b0;
        #60 u_if.sin = 1'b1;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check($sformatf("alt%0d", k), u_if.pout, alt_exp[k]);
        end
      end
    join

    // Mid-stream reset
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("load_ones", u_if.pout, 4'b1111);
    rst = 1'b0;
    step(1'b1);
    check("mid_reset", u_if.pout, 4'b0000);
    rst = 1'b1;
    step(1'b1);
    check("resume", u_if.pout, 4'b1000);

    // rst pulse entirely between edges must not clear
    u_if.sin = 1'b1;
    #5 rst = 1'b0;
    #5 rst = 1'b1;
    check("glitch_hold", u_if.pout, 4'b1000);
    @(posedge clk);
    @(negedge clk);
    check("glitch_shift", u_if.pout, 4'b1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
